shared_channel_arbiter: RTL
===========================

// Module: shared_channel_arbiter
// PURPOSE
//  Shares one byte-wide toggle-handshake channel (shared/get_it/put_it) between
//  NUM_REQ producers feeding a single consumer. Arbitration is round-robin.
//  The grant latches the winner's byte and toggles get_it, then waits for the
//  consumer to toggle put_it. Sits between producer-side requesters and one consumer.
// PARAMETERS
//  NUM_REQ         4    number of requesters, legal 2..16
//  OWNER_W         $clog2(NUM_REQ)  localparam, owner index width
//  TIMEOUT_CYCLES  255  max WAIT_ACK cycles before abort (used only with watchdog macro)
// PORTS
//  clk          in   1          single clock, all logic on posedge
//  reset        in   1          synchronous, active-high
//  req          in   NUM_REQ    level request per requester
//  data_in      in   NUM_REQ*8  byte per requester, requester i at [8*i+7:8*i]
//  done         out  NUM_REQ    1-cycle pulse: requester's byte acknowledged
//  shared       out  8          byte presented to consumer
//  get_it       out  1          toggles once per new byte on shared
//  put_it       in   1          consumer ack, toggles once per byte consumed
//  busy         out  1          high while in WAIT_ACK
//  owner        out  OWNER_W    index of current/last granted requester
//  timeout_err  out  1          sticky watchdog flag (tied 0 without macro)
// BEHAVIOUR
//  - Clock and reset: one clock; reset is synchronous and active-high (ports clk, reset).
//  - Reset: shared=0, get_it=0, done=0, busy=0, owner=0, timeout_err=0, state=IDLE.
//    last_owner=NUM_REQ-1, so requester 0 has first priority.
//    put_q<=put_it, so no spurious ack is seen after reset.
//  - Reset mid-transfer aborts the transfer. No done pulse.
//  - put_it is synchronous to clk. ack = (put_it != put_q). put_q <= put_it every cycle.
//  - FSM, two states:
//    IDLE: if |req at edge k, select the first set req scanning from last_owner+1
//      (mod NUM_REQ). At edge k: owner<=winner, shared<=data_in[winner],
//      get_it<=~get_it, busy<=1, state<=WAIT_ACK. Latency req->get_it toggle is 1 edge.
//      If no req, hold all outputs.
//    WAIT_ACK: shared and owner held stable. data_in and req changes are ignored;
//      dropping req does not abort the transfer.
//      On ack at edge m: done[owner]<=1 for one cycle, busy<=0,
//      last_owner<=owner, state<=IDLE.
//  - Earliest next grant is edge m+1, so at most 1 transfer per 2 cycles plus consumer latency.
//  - ack while IDLE is ignored: put_q absorbs it; no done, no state change.
//  - done is never multi-hot. At most one get_it toggle is outstanding at any time.
//  - The round-robin pointer advances only on completion (or abort); no requester starves.
// CONFIGURATION
//  SHARED_ARB_WATCHDOG_EN defined:
//   - Counter clears on entering WAIT_ACK and increments each WAIT_ACK cycle.
//   - If count==TIMEOUT_CYCLES with no ack: timeout_err<=1 (sticky until reset),
//     busy<=0, no done pulse, last_owner<=owner, state<=IDLE.
//   - ack and timeout in the same cycle: ack wins, normal completion.
//   - A late ack arriving after an abort is ignored (IDLE rule).
//  SHARED_ARB_WATCHDOG_EN undefined:
//   - No counter; WAIT_ACK waits indefinitely.
//   - timeout_err is a constant 0. TIMEOUT_CYCLES is unused.
// TESTING
//  1 reset held 3 cycles with req=4'hF -> shared=0, get_it=0, busy=0, done=0,
//    owner=0, timeout_err=0.
//  2 req=4'b0001, data0=8'h11 -> next edge: shared=8'h11, get_it 0->1, busy=1.
//    Consumer toggles put_it 3 cycles later -> done=4'b0001 for 1 cycle, busy=0.
//  3 req=4'hF held, data=8'hA0..8'hA3, consumer acks after 1 cycle ->
//    owner 0,1,2,3,0; shared A0,A1,A2,A3,A0; one get_it toggle each.
//  4 grant req2 (data 8'h5C), then change data2=8'hFF and drop req2 during WAIT_ACK ->
//    shared stays 8'h5C; ack gives done[2] pulse.
//  5 reset asserted during WAIT_ACK on owner 3 -> all outputs at reset values.
//    With req=4'b1001 afterwards, owner 0 is granted first.
//  6 (SHARED_ARB_WATCHDOG_EN, TIMEOUT_CYCLES=8) no ack -> after 8 WAIT_ACK cycles:
//    timeout_err=1, busy=0, no done, next requester granted.
//    Ack on cycle 8 -> done pulses, timeout_err stays 0.

Source files
------------

// File: rtl/shared_channel_arbiter.sv
// Round-robin share of one byte-wide toggle channel (shared/get_it/put_it); watchdog abort under SHARED_ARB_WATCHDOG_EN.
// Latency: req -> get_it toggle 1 edge; ack -> done pulse 1 edge; one transfer per 2 cycles minimum.
// Backpressure: at most one get_it toggle outstanding; requesters wait on req until granted and done.
module shared_channel_arbiter #(
    parameter int  NUM_REQ        = 4,
    parameter int  TIMEOUT_CYCLES = 255,
    localparam int OWNER_W        = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] data_in,
    output logic [NUM_REQ-1:0]   done,
    output logic [7:0]           shared,
    output logic                 get_it,
    input  logic                 put_it,
    output logic                 busy,
    output logic [OWNER_W-1:0]   owner,
    output logic                 timeout_err
);

    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("shared_channel_arbiter: illegal NUM_REQ or TIMEOUT_CYCLES");
    end

    typedef enum logic {IDLE, WAIT_ACK} state_t;

    state_t               state_q, state_d;
    logic [7:0]           shared_q, shared_d;
    logic                 get_it_q, get_it_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [OWNER_W-1:0]   owner_q, owner_d;
    logic [OWNER_W-1:0]   last_owner_q, last_owner_d;
    logic                 put_q;
    logic                 ack;

    logic                 win_vld;
    logic [OWNER_W-1:0]   win_idx;
    logic [7:0]           win_dat;

    assign ack = put_it ^ put_q;

    // Scan starts one past the last served requester so everyone gets a turn.
    always_comb begin
        int idx;
        win_vld = 1'b0;
        win_idx = '0;
        win_dat = '0;
        idx     = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_owner_q) + i) % NUM_REQ;
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win_idx = OWNER_W'(idx);
                win_dat = data_in[8*idx +: 8];
            end
        end
    end

`ifdef SHARED_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_err_q, timeout_err_d;
`endif

    always_comb begin
        state_d      = state_q;
        shared_d     = shared_q;
        get_it_d     = get_it_q;
        done_d       = '0;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
`ifdef SHARED_ARB_WATCHDOG_EN
        wd_cnt_d      = wd_cnt_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    owner_d  = win_idx;
                    shared_d = win_dat;
                    get_it_d = ~get_it_q;
                    state_d  = WAIT_ACK;
`ifdef SHARED_ARB_WATCHDOG_EN
                    wd_cnt_d = '0;
`endif
                end
            end
            WAIT_ACK: begin
`ifdef SHARED_ARB_WATCHDOG_EN
                wd_cnt_d = wd_cnt_q + 1'b1;
`endif
                if (ack) begin
                    done_d[owner_q] = 1'b1;
                    last_owner_d    = owner_q;
                    state_d         = IDLE;
                end
`ifdef SHARED_ARB_WATCHDOG_EN
                // Counter reads 0 in the first WAIT_ACK cycle, so this is cycle TIMEOUT_CYCLES.
                else if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_err_d = 1'b1;
                    last_owner_d  = owner_q;
                    state_d       = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            shared_q     <= '0;
            get_it_q     <= 1'b0;
            done_q       <= '0;
            owner_q      <= '0;
            last_owner_q <= OWNER_W'(NUM_REQ - 1);
            put_q        <= put_it;
`ifdef SHARED_ARB_WATCHDOG_EN
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shared_q     <= shared_d;
            get_it_q     <= get_it_d;
            done_q       <= done_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            put_q        <= put_it;
`ifdef SHARED_ARB_WATCHDOG_EN
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign shared = shared_q;
    assign get_it = get_it_q;
    assign done   = done_q;
    assign owner  = owner_q;
    assign busy   = (state_q == WAIT_ACK);
`ifdef SHARED_ARB_WATCHDOG_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
